// File: rtl/seven_seg_pkg.sv
// Shared definitions for the 7-segment display drivers.
//   SEG_BLANK / SEG_DASH : active-low glyphs (bit order g..a)
//   state_e              : score_display conversion FSM states
//   dec_limit(n)         : largest value representable in n decimal digits
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    UPDATE
  } state_e;

  // 10^n - 1; n is at most 8, so the result always fits in 32 bits.
  function automatic logic [31:0] dec_limit(input int unsigned n);
    logic [31:0] p;
    p = 32'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 32'd10;
    return p - 32'd1;
  endfunction

endpackage

// File: rtl/hex_decoder.sv
// Combinational nibble to active-low 7-segment glyph (bit order g..a).
//   nibble : 4-bit value 0..F
//   seg    : active-low segments, seg[0] = a ... seg[6] = g
module hex_decoder (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    unique case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// Multi-digit 7-segment driver. A load captures a binary value and shows it
// either as hex nibbles or as decimal (sequential double-dabble, one bit per
// clock), with optional leading-zero blanking and a dash pattern on overflow.
//   clk, reset         : clock, asynchronous active-high reset
//   value, load        : value to show, single-cycle load request (ignored while busy)
//   dec_mode, blank_lz : decimal/hex select, leading-zero blanking (sampled on load)
//   seg                : registered active-low segments, digit k at [7k+6:7k]
//   busy, done         : conversion in progress, one-cycle pulse when seg updates
//   overflow           : registered, value did not fit the display
module score_display
  import seven_seg_pkg::*;
#(
  parameter int VAL_W      = 16,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [VAL_W-1:0]        value,
  input  logic                    load,
  input  logic                    dec_mode,
  input  logic                    blank_lz,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  localparam int DIG_W = 4 * NUM_DIGITS;
  localparam int CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;
  localparam int CMP_W = (VAL_W > 32) ? VAL_W : 32;
  localparam logic [CMP_W-1:0] DEC_LIMIT = CMP_W'(dec_limit(NUM_DIGITS));

  state_e                  state_q, state_d;
  logic [VAL_W-1:0]        val_q, val_d;
  logic                    dec_q, dec_d;
  logic                    blank_q, blank_d;
  logic                    ovf_cap_q, ovf_cap_d;
  logic [DIG_W-1:0]        bcd_q, bcd_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
  logic                    overflow_q, overflow_d;
  logic                    done_q, done_d;

  logic                    hex_ovf;
  logic                    dec_ovf;
  logic [DIG_W-1:0]        nib;
  logic [DIG_W-1:0]        bcd_adj;
  logic [6:0]              hex_glyph [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] seg_new;

  if (VAL_W > DIG_W) begin : g_hex_ovf
    assign hex_ovf = |value[VAL_W-1:DIG_W];
  end else begin : g_no_hex_ovf
    assign hex_ovf = 1'b0;
  end

  assign dec_ovf = (CMP_W'(value) > DEC_LIMIT);

  // In decimal mode val_q is consumed by the shifter, but only bcd_q is shown.
  assign nib = dec_q ? bcd_q : DIG_W'(val_q);

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    hex_decoder u_hex_decoder (
      .nibble (nib[4*k +: 4]),
      .seg    (hex_glyph[k])
    );
  end

  // Glyph muxing: dash on overflow, blank for leading zeros above digit 0.
  always_comb begin
    logic all_zero;
    int unsigned k;
    seg_new  = '1;
    all_zero = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      k = NUM_DIGITS - 1 - i;
      all_zero = all_zero && (nib[4*k +: 4] == 4'd0);
      if (ovf_cap_q)
        seg_new[7*k +: 7] = SEG_DASH;
      else if (blank_q && (k > 0) && all_zero)
        seg_new[7*k +: 7] = SEG_BLANK;
      else
        seg_new[7*k +: 7] = hex_glyph[k];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      else
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
    end
  end

  always_comb begin
    state_d    = state_q;
    val_d      = val_q;
    dec_d      = dec_q;
    blank_d    = blank_q;
    ovf_cap_d  = ovf_cap_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    seg_d      = seg_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          val_d     = value;
          dec_d     = dec_mode;
          blank_d   = blank_lz;
          ovf_cap_d = dec_mode ? dec_ovf : hex_ovf;
          bcd_d     = '0;
          cnt_d     = '0;
          state_d   = dec_mode ? CONVERT : UPDATE;
        end
      end
      CONVERT: begin
        // Top-nibble carry-out is dropped; overflow was decided at capture.
        bcd_d = {bcd_adj[DIG_W-2:0], val_q[VAL_W-1]};
        val_d = val_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(VAL_W - 1)) begin
          cnt_d   = '0;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        seg_d      = seg_new;
        overflow_d = ovf_cap_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      val_q      <= '0;
      dec_q      <= 1'b0;
      blank_q    <= 1'b0;
      ovf_cap_q  <= 1'b0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      seg_q      <= '1;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      val_q      <= val_d;
      dec_q      <= dec_d;
      blank_q    <= blank_d;
      ovf_cap_q  <= ovf_cap_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      seg_q      <= seg_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign seg      = seg_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule
